// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Opcode constants, FSM state type and opcode classification
//             shared by seq_alu and the processor control unit.
//  Config   : SEQ_ALU_DIV_EN - when defined, DIVU/REMU are multi-cycle ops.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_DIVU = 4'b0100;
  localparam logic [3:0] ALU_REMU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_LESS = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

  // True for opcodes handled by the iterative multiply/divide datapath
  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
    return (op == ALU_MUL);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_muldiv
//  Purpose  : Iterative one-bit-per-cycle shift-add multiplier and (optional)
//             restoring divider. Exposes the value the final iteration will
//             produce so the parent can register it on the last cycle.
//  Config   : SEQ_ALU_DIV_EN - adds the divider datapath and the op port.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             busy,
`ifdef SEQ_ALU_DIV_EN
  input  logic [3:0]       op,
`endif
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             last,
  output logic [WIDTH-1:0] res_next
);

  localparam int CW = $clog2(WIDTH) + 1;

  // acc: product accumulator / partial remainder
  // a  : multiplicand (shifts left) / divisor
  // b  : multiplier (shifts right) / dividend turning into quotient
  logic [WIDTH-1:0] r_acc, r_a, r_b;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc_nx, w_a_nx, w_b_nx;

`ifdef SEQ_ALU_DIV_EN
  logic             r_div, r_rem;
  logic [WIDTH:0]   w_rs, w_diff;
`endif

  // One iteration step of the active operation
  always_comb begin
    w_acc_nx = r_acc + (r_b[0] ? r_a : '0);
    w_a_nx   = r_a << 1;
    w_b_nx   = r_b >> 1;
    res_next = w_acc_nx;
`ifdef SEQ_ALU_DIV_EN
    w_rs   = {r_acc, r_b[WIDTH-1]};
    w_diff = w_rs - {1'b0, r_a};
    if (r_div) begin
      w_a_nx = r_a;
      if (!w_diff[WIDTH]) begin
        w_acc_nx = w_diff[WIDTH-1:0];
        w_b_nx   = {r_b[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nx = w_rs[WIDTH-1:0];
        w_b_nx   = {r_b[WIDTH-2:0], 1'b0};
      end
      res_next = r_rem ? w_acc_nx : w_b_nx;
    end
`endif
  end

  assign last = busy && (r_cnt == CW'(WIDTH - 1));

  // Operand load on start, then one iteration per busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
`ifdef SEQ_ALU_DIV_EN
      r_div <= 1'b0;
      r_rem <= 1'b0;
`endif
    end else if (start) begin
      r_acc <= '0;
      r_a   <= op2;
      r_b   <= op1;
      r_cnt <= '0;
`ifdef SEQ_ALU_DIV_EN
      r_div <= (op != ALU_MUL);
      r_rem <= (op == ALU_REMU);
      if (op == ALU_MUL) begin
        r_a <= op1;
        r_b <= op2;
      end
`else
      r_a   <= op1;
      r_b   <= op2;
`endif
    end else if (busy) begin
      r_acc <= w_acc_nx;
      r_a   <= w_a_nx;
      r_b   <= w_b_nx;
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Sequential ALU with valid/ready handshakes. Single-cycle ops
//             finish one cycle after acceptance; MUL (and DIVU/REMU when
//             enabled) iterate WIDTH cycles in seq_alu_muldiv.
//  Config   : SEQ_ALU_DIV_EN - enables the iterative DIVU/REMU; otherwise
//             those codes are single-cycle and return 0.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  alu_state_t       r_state, w_state_nx;
  logic             w_accept, w_multi, w_last;
  logic [WIDTH-1:0] w_single, w_md_res;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_multi   = is_multicycle(alu_op);

  // Single-cycle operation results straight from the request operands
  always_comb begin
    w_single = '0;
    case (alu_op)
      ALU_AND:  w_single = op1 & op2;
      ALU_OR:   w_single = op1 | op2;
      ALU_XOR:  w_single = op1 ^ op2;
      ALU_ADD:  w_single = op1 + op2;
      ALU_SUB:  w_single = op1 - op2;
      ALU_LESS: w_single = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SRL:  w_single = op1 >> op2[SHW-1:0];
      ALU_SLL:  w_single = op1 << op2[SHW-1:0];
      ALU_SRA:  w_single = $signed(op1) >>> op2[SHW-1:0];
      default:  w_single = '0;
    endcase
  end

  // Next-state logic for the IDLE -> (BUSY) -> DONE handshake sequence
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = w_multi ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_nx = S_DONE;
      S_DONE:  if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Result and zero flag, captured together and held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (w_accept && !w_multi) begin
      result <= w_single;
      zero   <= (w_single == '0);
    end else if (w_last) begin
      result <= w_md_res;
      zero   <= (w_md_res == '0);
    end
  end

  seq_alu_muldiv #(
    .WIDTH    (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_accept && w_multi),
    .busy     (r_state == S_BUSY),
`ifdef SEQ_ALU_DIV_EN
    .op       (alu_op),
`endif
    .op1      (op1),
    .op2      (op2),
    .last     (w_last),
    .res_next (w_md_res)
  );

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Self-checking bench for seq_alu: directed corner cases plus
//             random operations checked against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]   alu_op;
  logic [W-1:0] op1, op2, result;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_res;
  logic         exp_pending = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  function automatic bit div_en();
`ifdef SEQ_ALU_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit multi(input logic [3:0] op);
    return (op == 4'b0011) || (div_en() && (op == 4'b0100 || op == 4'b0101));
  endfunction

  // Reference behaviour written from the opcode definitions
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    longint unsigned prod;
    sh = int'(b % W);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (int'(a) < int'(b)) ? 1 : 0;
      4'b1000: return a >> sh;
      4'b1001: return a << sh;
      4'b1010: return W'(int'(a) >>> sh);
      4'b1101: return a ^ b;
      4'b0011: begin prod = longint'(a) * longint'(b); return prod[W-1:0]; end
      4'b0100: return !div_en() ? '0 : (b == 0) ? '1 : a / b;
      4'b0101: return !div_en() ? '0 : (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Every cycle a result is presented, it must match the outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("valid_expected", exp_pending, 1);
      chk("result", result, exp_res);
      chk("zero", zero, exp_res == '0);
    end
  end

  // Issue one request, check latency and ready behaviour, hold in DONE, release
  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] want, input int hold);
    int cyc;
    bit rdy_bad;
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk({name, "_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; alu_op = op; op1 = a; op2 = b;
    @(posedge clk); #1;
    exp_res = want; exp_pending = 1'b1;
    in_valid = 1'b0; op1 = $urandom; op2 = $urandom; alu_op = 4'($urandom);
    cyc = 0; rdy_bad = 0;
    do begin
      @(negedge clk); cyc++;
      if (in_ready) rdy_bad = 1;
      op1 = $urandom; op2 = $urandom;
    end while (!out_valid && cyc < W + 10);
    chk({name, "_latency"}, cyc, multi(op) ? W + 1 : 1);
    chk({name, "_ready_low"}, rdy_bad, 0);
    repeat (hold) begin
      in_valid = 1'($urandom);
      @(negedge clk);
    end
    chk({name, "_held_valid"}, out_valid, 1);
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    exp_pending = 1'b0;
    chk({name, "_back_idle"}, {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] ops [14];
    logic [3:0] op;
    logic [W-1:0] a, b;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001,
            4'b1010, 4'b1101, 4'b0011, 4'b0100, 4'b0101, 4'b1111, 4'b1011};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {out_valid, zero, result}, {1'b0, 1'b1, 32'h0});
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
    do_op("sub_zero", 4'b0110, 32'h1234, 32'h1234, 32'h0, 1);
    do_op("sra", 4'b1010, 32'h8000_0000, 32'h24, 32'hF800_0000, 0);
    do_op("mul", 4'b0011, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD, 0);
    do_op("divu", 4'b0100, 32'd100, 32'd7, div_en() ? 32'd14 : 32'd0, 0);
    do_op("remu", 4'b0101, 32'd100, 32'd7, div_en() ? 32'd2 : 32'd0, 0);
    do_op("divu0", 4'b0100, 32'd5, 32'd0, div_en() ? 32'hFFFF_FFFF : 32'd0, 0);
    do_op("remu0", 4'b0101, 32'd5, 32'd0, div_en() ? 32'd5 : 32'd0, 0);
    do_op("less_neg", 4'b0111, 32'hFFFF_FFFE, 32'h1, 32'h1, 0);
    do_op("xor_hold", 4'b1101, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 32'hAAAA_AAAA, 5);
    do_op("bad_op", 4'b1111, 32'h1, 32'h2, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 13)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      do_op("rand", op, a, b, model(op, a, b), $urandom_range(0, 3));
    end

    // Reset in the middle of a multiply must abort it without a result
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'b0011; op1 = 32'd5; op2 = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst", {out_valid, zero, result}, {1'b0, 1'b1, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {in_ready, out_valid}, 2'b10);
    do_op("add_after_rst", 4'b0010, 32'd2, 32'd2, 32'd4, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
